tomasulo_regfile_tagged: RTL
============================

Name: tomasulo_regfile_tagged

Overview:
- Parametrised architectural register file for the Tomasulo core; each entry holds a data value plus a producer label (reservation-station tag).
- Issue stage renames a destination by writing a label into an entry.
- Common Data Bus (CDB) broadcasts retire matching labels: data is written and the label is cleared in one cycle.
- Two combinational read ports supply operand data and label to reservation-station allocation. A flush clears all pending labels after a squash.

Parameters:
- DATA_W, 9, width of each register data field.
- TAG_W, 9, width of each label field.
- NREGS, 8, number of registers (power of two, >=2).
- ADDR_W, $clog2(NREGS), register address width.
- RESET_DATA, 2, data value loaded into every entry at reset.
- NO_TAG, all ones of TAG_W (9'h1FF), label meaning "value valid, no pending producer".

Ports:
- clk  in  1  single system clock, all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- issue_valid  in  1  rename request this cycle.
- issue_rd  in  ADDR_W  destination register being renamed.
- issue_tag  in  TAG_W  producing reservation-station tag.
- cdb_valid  in  1  CDB broadcast this cycle.
- cdb_tag  in  TAG_W  tag of the completing station.
- cdb_data  in  DATA_W  result value.
- flush  in  1  clear all labels to NO_TAG.
- rs_addr, rt_addr  in  ADDR_W  read port addresses.
- rs_data, rt_data  out  DATA_W  read data.
- rs_tag, rt_tag  out  TAG_W  read label.
- pending_cnt  out  $clog2(NREGS+1)  number of entries whose label != NO_TAG.
- issue_err  out  1  registered, one-cycle pulse on an illegal issue.

Behaviour:
- Reset (async, rst_n=0): every data entry = RESET_DATA, every label = NO_TAG, pending_cnt = 0, issue_err = 0. Deassertion is synchronous to clk from the design's point of view. Reset mid-operation discards all pending labels.
- Register state per entry i, evaluated each rising edge:
  - CDB hit: cdb_valid && label[i]==cdb_tag && cdb_tag!=NO_TAG → data[i] <= cdb_data, label[i] <= NO_TAG.
  - Issue: issue_valid && issue_rd==i && issue_tag!=NO_TAG → label[i] <= issue_tag. Data is unchanged by issue.
  - Same-cycle issue and CDB hit on the same entry: data takes cdb_data, label takes issue_tag. The newer producer wins.
  - Multiple entries matching cdb_tag: all are updated in the same cycle.
  - cdb_tag == NO_TAG: broadcast is ignored entirely.
- Flush (priority over issue and CDB for labels): all labels <= NO_TAG. Data still accepts a same-cycle CDB hit, with matching evaluated against the pre-flush labels. An issue in the flush cycle is dropped.
- Illegal issue: issue_valid with issue_tag==NO_TAG → no state change; issue_err=1 on the next cycle for one cycle. A legal issue or no issue gives issue_err=0 next cycle.
- pending_cnt: registered. Equals the count of non-NO_TAG labels after the edge (same cycle as the label update). Range 0..NREGS; no wrap.
- Read ports: combinational from current state. rs and rt may alias the same entry, each other, or issue_rd. Reads never see the same-cycle issue; the new label is visible next cycle.
- No write-after-write check: re-issuing to a pending register overwrites its label. The old tag's later CDB broadcast then misses that entry, which is intended.

Optional Feature:
- Macro REGFILE_CDB_FORWARD_EN.
- Defined: read ports forward from the same-cycle CDB. If cdb_valid, cdb_tag!=NO_TAG and the addressed label==cdb_tag, then the port outputs data=cdb_data and tag=NO_TAG combinationally. Flush does not affect forwarding.
- Not defined: read ports show registered state only; the CDB result is visible the cycle after broadcast.

Test Plan:
- Reset: assert rst_n=0 mid-run → all reads give data 9'h002, tag 9'h1FF; pending_cnt=0; issue_err=0 without waiting for a clock.
- Rename then retire: issue rd=3 tag=9'h005 → rs_addr=3 reads tag 9'h005 next cycle, pending_cnt=1. Then CDB tag=9'h005 data=9'h0AB → next cycle data 9'h0AB, tag 9'h1FF, pending_cnt=0.
- Multi-match broadcast: regs 1,2,6 all issued tag 9'h010 → one CDB with data 9'h077 updates all three; pending_cnt steps 3→0 in one edge.
- Same-cycle collision: reg 4 pending tag 9'h007; CDB tag 9'h007 data 9'h033 together with issue rd=4 tag 9'h009 → data 9'h033, tag 9'h009, pending_cnt unchanged at 1.
- Flush and illegal issue: 5 entries pending, flush=1 → pending_cnt=0, all tags 9'h1FF. Then issue tag=9'h1FF → no change, issue_err pulses 1 for exactly one cycle.
- Forwarding: reg 0 pending tag 9'h002; CDB tag 9'h002 data 9'h155 with rs_addr=0.
  - With REGFILE_CDB_FORWARD_EN: rs_data=9'h155, rs_tag=9'h1FF in the same cycle.
  - Without it: old data and tag 9'h002 in that cycle, updated values the next cycle.

Source files
------------

// File: rtl/tomasulo_regfile_tagged.sv
// Tagged architectural register file: each entry holds data plus a producer tag, renamed at issue and retired by CDB.
// Optional macro REGFILE_CDB_FORWARD_EN forwards a same-cycle CDB hit onto the read ports.
module tomasulo_regfile_tagged #(
    parameter int               DATA_W     = 9,
    parameter int               TAG_W      = 9,
    parameter int               NREGS      = 8,
    parameter int               ADDR_W     = $clog2(NREGS),
    parameter int               RESET_DATA = 2,
    parameter logic [TAG_W-1:0] NO_TAG     = '1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         issue_valid,
    input  logic [ADDR_W-1:0]            issue_rd,
    input  logic [TAG_W-1:0]             issue_tag,
    input  logic                         cdb_valid,
    input  logic [TAG_W-1:0]             cdb_tag,
    input  logic [DATA_W-1:0]            cdb_data,
    input  logic                         flush,
    input  logic [ADDR_W-1:0]            rs_addr,
    input  logic [ADDR_W-1:0]            rt_addr,
    output logic [DATA_W-1:0]            rs_data,
    output logic [DATA_W-1:0]            rt_data,
    output logic [TAG_W-1:0]             rs_tag,
    output logic [TAG_W-1:0]             rt_tag,
    output logic [$clog2(NREGS+1)-1:0]   pending_cnt,
    output logic                         issue_err
);
    localparam int CNT_W = $clog2(NREGS+1);

    logic [DATA_W-1:0] dataMem  [NREGS];
    logic [TAG_W-1:0]  tagMem   [NREGS];
    logic [DATA_W-1:0] dataNext [NREGS];
    logic [TAG_W-1:0]  tagNext  [NREGS];
    logic [CNT_W-1:0]  countNext;
    logic              cdbLive;
    logic              issueLegal;
    logic              cdbHit;

    assign cdbLive    = cdb_valid && (cdb_tag != NO_TAG);
    assign issueLegal = issue_valid && (issue_tag != NO_TAG);

    // Hits are matched against the current labels, so flush never hides a retiring result from the data.
    always_comb begin
        countNext = '0;
        cdbHit    = 1'b0;
        for (int i = 0; i < NREGS; i++) begin
            cdbHit      = cdbLive && (tagMem[i] == cdb_tag);
            dataNext[i] = cdbHit ? cdb_data : dataMem[i];
            if (flush)
                tagNext[i] = NO_TAG;
            else if (issueLegal && (issue_rd == ADDR_W'(i)))
                tagNext[i] = issue_tag;
            else if (cdbHit)
                tagNext[i] = NO_TAG;
            else
                tagNext[i] = tagMem[i];
            if (tagNext[i] != NO_TAG)
                countNext = countNext + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                dataMem[i] <= DATA_W'(RESET_DATA);
                tagMem[i]  <= NO_TAG;
            end
            pending_cnt <= '0;
            issue_err   <= 1'b0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                dataMem[i] <= dataNext[i];
                tagMem[i]  <= tagNext[i];
            end
            pending_cnt <= countNext;
            issue_err   <= issue_valid && (issue_tag == NO_TAG);
        end
    end

    always_comb begin
        rs_data = dataMem[rs_addr];
        rs_tag  = tagMem[rs_addr];
        rt_data = dataMem[rt_addr];
        rt_tag  = tagMem[rt_addr];
`ifdef REGFILE_CDB_FORWARD_EN
        if (cdbLive && (tagMem[rs_addr] == cdb_tag)) begin
            rs_data = cdb_data;
            rs_tag  = NO_TAG;
        end
        if (cdbLive && (tagMem[rt_addr] == cdb_tag)) begin
            rt_data = cdb_data;
            rt_tag  = NO_TAG;
        end
`else
`endif
    end

endmodule
